// File: rtl/axis_processor_arbiter_pkg.sv
// Shared types and defaults for the round-robin front end that lets several
// AXI-Stream requesters take turns on one axis_processor.
package axis_arbiter_config;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;

  localparam int DEFAULT_NUM_REQ       = 4;
  localparam int PROC_INP_WIDTH        = 8;
  localparam int PROC_OUT_WIDTH        = 8;
  localparam int DEFAULT_RSP_CNT_WIDTH = 16;

  function automatic int reqIdxWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/axis_processor_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import axis_arbiter_config::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int REQ_IDX_WIDTH = reqIdxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]       req,
  input  logic [REQ_IDX_WIDTH-1:0] ptr,
  output logic [REQ_IDX_WIDTH-1:0] gnt_idx,
  output logic                     gnt_any
);

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && req[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_idx = REQ_IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/axis_processor_arbiter.sv
// Grants one shared axis_processor to one requester per job and routes the
// declared number of response beats back to that same requester.
module axis_processor_arbiter
  import axis_arbiter_config::*;
#(
  parameter int NUM_REQ       = DEFAULT_NUM_REQ,
  parameter int INP_WIDTH     = PROC_INP_WIDTH,
  parameter int OUT_WIDTH     = PROC_OUT_WIDTH,
  parameter int RSP_CNT_WIDTH = DEFAULT_RSP_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [NUM_REQ*INP_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_REQ-1:0]               s_axis_tvalid,
  output logic [NUM_REQ-1:0]               s_axis_tready,
  input  logic [NUM_REQ-1:0]               s_axis_tlast,
  input  logic [NUM_REQ*RSP_CNT_WIDTH-1:0] s_axis_tuser,
  output logic [INP_WIDTH-1:0]             p_s_axis_tdata,
  output logic                             p_s_axis_tvalid,
  input  logic                             p_s_axis_tready,
  input  logic [OUT_WIDTH-1:0]             p_m_axis_tdata,
  input  logic                             p_m_axis_tvalid,
  output logic                             p_m_axis_tready,
  output logic [OUT_WIDTH-1:0]             m_axis_tdata,
  output logic [NUM_REQ-1:0]               m_axis_tvalid,
  input  logic [NUM_REQ-1:0]               m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy,
  output logic                             err_unexpected
);

  localparam int REQ_IDX_WIDTH = reqIdxWidth(NUM_REQ);
  localparam logic [REQ_IDX_WIDTH-1:0] LAST_IDX = REQ_IDX_WIDTH'(NUM_REQ - 1);

  arb_state_t               r_state;
  logic [REQ_IDX_WIDTH-1:0] r_rrPtr;
  logic [REQ_IDX_WIDTH-1:0] r_grantId;
  logic [RSP_CNT_WIDTH-1:0] r_remaining;
  logic                     r_inDone;
  logic                     r_errUnexpected;

  logic [REQ_IDX_WIDTH-1:0] w_selIdx;
  logic                     w_selAny;
  logic                     w_inPhase;
  logic                     w_rspPhase;
  logic                     w_inHs;
  logic                     w_rspHs;
  logic                     w_jobInDone;
  logic [RSP_CNT_WIDTH-1:0] w_remNext;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (s_axis_tvalid),
    .ptr     (r_rrPtr),
    .gnt_idx (w_selIdx),
    .gnt_any (w_selAny)
  );

  // Responses are only routed while the job still owes beats; anything else stays stalled in the processor.
  assign w_inPhase   = (r_state == GRANT) && !r_inDone;
  assign w_rspPhase  = (r_state != IDLE) && (r_remaining != '0);
  assign w_inHs      = w_inPhase && s_axis_tvalid[r_grantId] && p_s_axis_tready;
  assign w_rspHs     = w_rspPhase && p_m_axis_tvalid && m_axis_tready[r_grantId];
  assign w_remNext   = r_remaining - RSP_CNT_WIDTH'(w_rspHs);
  assign w_jobInDone = r_inDone || (w_inHs && s_axis_tlast[r_grantId]);

  always_comb begin
    s_axis_tready            = '0;
    m_axis_tvalid            = '0;
    s_axis_tready[r_grantId] = w_inPhase && p_s_axis_tready;
    m_axis_tvalid[r_grantId] = w_rspPhase && p_m_axis_tvalid;
    p_s_axis_tvalid          = w_inPhase && s_axis_tvalid[r_grantId];
    p_s_axis_tdata           = w_inPhase ? s_axis_tdata[r_grantId*INP_WIDTH +: INP_WIDTH] : '0;
    p_m_axis_tready          = w_rspPhase && m_axis_tready[r_grantId];
    m_axis_tlast             = w_rspPhase && (r_remaining == RSP_CNT_WIDTH'(1));
    m_axis_tdata             = p_m_axis_tdata;
  end

  assign grant_id       = r_grantId;
  assign busy           = (r_state != IDLE);
  assign err_unexpected = r_errUnexpected;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state         <= IDLE;
      r_rrPtr         <= '0;
      r_grantId       <= '0;
      r_remaining     <= '0;
      r_inDone        <= 1'b0;
      r_errUnexpected <= 1'b0;
    end else begin
      if (p_m_axis_tvalid && (r_remaining == '0))
        r_errUnexpected <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_selAny) begin
            r_grantId   <= w_selIdx;
            r_remaining <= s_axis_tuser[w_selIdx*RSP_CNT_WIDTH +: RSP_CNT_WIDTH];
            r_inDone    <= 1'b0;
            r_rrPtr     <= (w_selIdx == LAST_IDX) ? '0 : w_selIdx + 1'b1;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          r_remaining <= w_remNext;
          if (w_inHs && s_axis_tlast[r_grantId])
            r_inDone <= 1'b1;
          // The last input beat and the last response may land together; release straight away then.
          if (w_jobInDone)
            r_state <= (w_remNext == '0) ? IDLE : DRAIN;
        end
        DRAIN: begin
          r_remaining <= w_remNext;
          if (w_remNext == '0)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Directed bench for axis_processor_arbiter with four 8-bit requesters and
// hand-computed expectations for grant order, routing, backpressure and reset.
module tb_axis_processor_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] sTdata;
  logic [3:0]  sTvalid, sTready, sTlast;
  logic [63:0] sTuser;
  logic [7:0]  pSTdata, pMTdata, mTdata;
  logic        pSTvalid, pSTready, pMTvalid, pMTready, mTlast;
  logic [3:0]  mTvalid, mTready;
  logic [1:0]  grantId;
  logic        busy, errUnexpected;
  int          total = 0;
  int          bad = 0;

  axis_processor_arbiter #(
    .NUM_REQ(4), .INP_WIDTH(8), .OUT_WIDTH(8), .RSP_CNT_WIDTH(16)
  ) dut (
    .clk             (clk),
    .arst            (arst),
    .s_axis_tdata    (sTdata),
    .s_axis_tvalid   (sTvalid),
    .s_axis_tready   (sTready),
    .s_axis_tlast    (sTlast),
    .s_axis_tuser    (sTuser),
    .p_s_axis_tdata  (pSTdata),
    .p_s_axis_tvalid (pSTvalid),
    .p_s_axis_tready (pSTready),
    .p_m_axis_tdata  (pMTdata),
    .p_m_axis_tvalid (pMTvalid),
    .p_m_axis_tready (pMTready),
    .m_axis_tdata    (mTdata),
    .m_axis_tvalid   (mTvalid),
    .m_axis_tready   (mTready),
    .m_axis_tlast    (mTlast),
    .grant_id        (grantId),
    .busy            (busy),
    .err_unexpected  (errUnexpected)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    arst = 1'b1; sTdata = '0; sTvalid = '0; sTlast = '0; sTuser = '0;
    pSTready = 1'b0; pMTdata = '0; pMTvalid = 1'b0; mTready = '0;
    #3;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant", grantId, 2'd0);
    checkOutput("rst_s_tready", sTready, 4'b0000);
    checkOutput("rst_m_tvalid", mTvalid, 4'b0000);
    checkOutput("rst_p_s_tvalid", pSTvalid, 1'b0);
    checkOutput("rst_p_m_tready", pMTready, 1'b0);
    checkOutput("rst_m_tlast", mTlast, 1'b0);
    checkOutput("rst_err", errUnexpected, 1'b0);
    @(posedge clk); #1;
    arst = 1'b0;

    // Single job: requester 2, three beats, two responses
    sTdata[23:16] = 8'hA1; sTuser[47:32] = 16'd2; sTvalid = 4'b0100;
    pSTready = 1'b1; mTready = 4'b0100;
    settle();
    checkOutput("idle_s_tready", sTready, 4'b0000);
    checkOutput("idle_p_s_tvalid", pSTvalid, 1'b0);
    cycle();
    checkOutput("j1_grant", grantId, 2'd2);
    checkOutput("j1_busy", busy, 1'b1);
    checkOutput("j1_s_tready", sTready, 4'b0100);
    checkOutput("j1_p_s_tvalid", pSTvalid, 1'b1);
    checkOutput("j1_p_s_tdata1", pSTdata, 8'hA1);
    cycle();
    sTdata[23:16] = 8'hA2; settle();
    checkOutput("j1_p_s_tdata2", pSTdata, 8'hA2);
    cycle();
    sTdata[23:16] = 8'hA3; sTlast = 4'b0100; settle();
    checkOutput("j1_p_s_tdata3", pSTdata, 8'hA3);
    cycle();
    sTvalid = '0; sTlast = '0; pMTvalid = 1'b1; pMTdata = 8'h51; settle();
    checkOutput("j1_drain_s_tready", sTready, 4'b0000);
    checkOutput("j1_drain_busy", busy, 1'b1);
    checkOutput("j1_m_tvalid1", mTvalid, 4'b0100);
    checkOutput("j1_p_m_tready1", pMTready, 1'b1);
    checkOutput("j1_m_tlast1", mTlast, 1'b0);
    checkOutput("j1_m_tdata1", mTdata, 8'h51);
    cycle();
    pMTdata = 8'h52; settle();
    checkOutput("j1_m_tlast2", mTlast, 1'b1);
    checkOutput("j1_m_tvalid2", mTvalid, 4'b0100);
    cycle();
    pMTvalid = 1'b0; settle();
    checkOutput("j1_release_busy", busy, 1'b0);
    checkOutput("j1_rr_ptr", dut.r_rrPtr, 2'd3);
    checkOutput("j1_err", errUnexpected, 1'b0);

    // Contention from reset: 0,1,3 valid, one-beat zero-response jobs
    arst = 1'b1; settle(); arst = 1'b0;
    checkOutput("c_rr_ptr_rst", dut.r_rrPtr, 2'd0);
    sTvalid = 4'b1011; sTlast = 4'b1111; sTuser = '0; mTready = '0;
    cycle();
    checkOutput("c_grant0", grantId, 2'd0);
    checkOutput("c_s_tready0", sTready, 4'b0001);
    cycle();
    checkOutput("c_idle_busy", busy, 1'b0);
    checkOutput("c_idle_s_tready", sTready, 4'b0000);
    cycle();
    checkOutput("c_grant1", grantId, 2'd1);
    checkOutput("c_s_tready1", sTready, 4'b0010);
    cycle();
    cycle();
    checkOutput("c_grant3", grantId, 2'd3);
    checkOutput("c_s_tready3", sTready, 4'b1000);
    cycle();
    cycle();
    checkOutput("c_grant0_again", grantId, 2'd0);
    checkOutput("c_s_tready0_again", sTready, 4'b0001);
    cycle();
    sTvalid = '0; sTlast = '0; settle();
    checkOutput("c_end_busy", busy, 1'b0);
    checkOutput("c_rr_ptr", dut.r_rrPtr, 2'd1);

    // Backpressure: requester 1, three responses, ready held low five cycles
    sTvalid = 4'b0010; sTlast = 4'b0010; sTuser[31:16] = 16'd3;
    cycle();
    checkOutput("bp_grant", grantId, 2'd1);
    cycle();
    sTvalid = '0; sTlast = '0; pMTvalid = 1'b1; pMTdata = 8'h77; mTready = '0; settle();
    checkOutput("bp_busy", busy, 1'b1);
    checkOutput("bp_m_tvalid", mTvalid, 4'b0010);
    checkOutput("bp_p_m_tready", pMTready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("bp_hold_p_m_tready", pMTready, 1'b0);
      checkOutput("bp_hold_m_tlast", mTlast, 1'b0);
      checkOutput("bp_hold_m_tdata", mTdata, 8'h77);
      checkOutput("bp_hold_busy", busy, 1'b1);
    end
    mTready = 4'b0010; settle();
    checkOutput("bp_release_p_m_tready", pMTready, 1'b1);
    checkOutput("bp_rem3_m_tlast", mTlast, 1'b0);
    cycle();
    checkOutput("bp_rem2_m_tlast", mTlast, 1'b0);
    cycle();
    checkOutput("bp_rem1_m_tlast", mTlast, 1'b1);
    cycle();
    pMTvalid = 1'b0; mTready = '0; settle();
    checkOutput("bp_end_busy", busy, 1'b0);
    checkOutput("bp_err", errUnexpected, 1'b0);
    checkOutput("bp_rr_ptr", dut.r_rrPtr, 2'd2);

    // Zero-response job on requester 2, then an unsolicited response
    sTvalid = 4'b0100; sTlast = 4'b0100; sTuser = '0;
    cycle();
    checkOutput("z_grant", grantId, 2'd2);
    checkOutput("z_p_m_tready", pMTready, 1'b0);
    cycle();
    sTvalid = '0; sTlast = '0; settle();
    checkOutput("z_busy", busy, 1'b0);
    checkOutput("z_err_clear", errUnexpected, 1'b0);
    pMTvalid = 1'b1; settle();
    checkOutput("z_inject_p_m_tready", pMTready, 1'b0);
    checkOutput("z_inject_m_tvalid", mTvalid, 4'b0000);
    cycle();
    checkOutput("z_err_set", errUnexpected, 1'b1);
    pMTvalid = 1'b0;
    cycle();
    checkOutput("z_err_sticky", errUnexpected, 1'b1);

    // Same-cycle release: requester 3, two beats, one response on the last beat
    sTvalid = 4'b1000; sTlast = '0; sTuser[63:48] = 16'd1; mTready = 4'b1000;
    cycle();
    checkOutput("s_grant", grantId, 2'd3);
    cycle();
    sTlast = 4'b1000; pMTvalid = 1'b1; pMTdata = 8'h99; settle();
    checkOutput("s_p_s_tvalid", pSTvalid, 1'b1);
    checkOutput("s_m_tvalid", mTvalid, 4'b1000);
    checkOutput("s_m_tlast", mTlast, 1'b1);
    checkOutput("s_p_m_tready", pMTready, 1'b1);
    cycle();
    sTvalid = '0; sTlast = '0; pMTvalid = 1'b0; settle();
    checkOutput("s_direct_idle", busy, 1'b0);
    checkOutput("s_rr_ptr", dut.r_rrPtr, 2'd0);

    // Mid-job reset while draining with four responses owed
    sTvalid = 4'b0001; sTlast = 4'b0001; sTuser = '0; sTuser[15:0] = 16'd4; mTready = 4'b0001;
    cycle();
    cycle();
    sTvalid = '0; sTlast = '0; pMTvalid = 1'b1; settle();
    checkOutput("r_pre_busy", busy, 1'b1);
    checkOutput("r_pre_m_tvalid", mTvalid, 4'b0001);
    checkOutput("r_pre_p_m_tready", pMTready, 1'b1);
    checkOutput("r_pre_m_tlast", mTlast, 1'b0);
    arst = 1'b1;
    #1;
    checkOutput("r_m_tvalid", mTvalid, 4'b0000);
    checkOutput("r_p_m_tready", pMTready, 1'b0);
    checkOutput("r_busy", busy, 1'b0);
    checkOutput("r_grant", grantId, 2'd0);
    checkOutput("r_err", errUnexpected, 1'b0);
    checkOutput("r_s_tready", sTready, 4'b0000);
    checkOutput("r_p_s_tvalid", pSTvalid, 1'b0);
    checkOutput("r_m_tlast", mTlast, 1'b0);
    checkOutput("r_rr_ptr", dut.r_rrPtr, 2'd0);
    pMTvalid = 1'b0; mTready = '0; settle();
    arst = 1'b0;
    cycle();
    checkOutput("r_after_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
